// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: parity encodings, TX/RX state enums
// and a parity helper that only looks at the configured number of data bits.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic logic calc_parity(input logic [7:0] data, input int data_bits,
                                       input int parity);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) p = p ^ data[i];
    end
    return (parity == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Transmit half of the UART: latches a byte on the valid/ready handshake and
// shifts out start, data (LSB first), optional parity and stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 234,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]    DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          bit_done;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    bit_done = (cnt_q == CNT_LAST);

    if (state_q != TX_IDLE) cnt_d = bit_done ? '0 : cnt_q + 1'b1;

    case (state_q)
      TX_IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d = tx_data & DATA_MASK;
          par_d   = calc_parity(tx_data, DATA_BITS, PARITY);
          cnt_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = TX_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = TX_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        // ready returns on the cycle right after the final stop-bit cycle
        if (bit_done) begin
          if (bit_q == STOP_LAST) begin
            ready_d = 1'b1;
            state_d = TX_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  assign uart_tx  = tx_q;
  assign tx_ready = ready_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: instantiates the TX serializer and holds the RX path
// (synchroniser, glitch-rejecting receive FSM, output holding register).
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 234,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);

  uart_tx_serializer #(
    .CLK_DIV  (CLK_DIV),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx (uart_tx)
  );

  logic          meta_q, sync_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          perr_pend_q, perr_pend_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_perr_q, rx_perr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          bit_done;
  logic          deliver;
  logic          frame_bad;
  logic [7:0]    rx_word;

  // Bits enter at the top of the shift register, so narrow frames end up high-aligned.
  assign rx_word = rx_shift_q >> (8 - DATA_BITS);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    perr_pend_d = perr_pend_q;
    deliver     = 1'b0;
    frame_bad   = 1'b0;
    bit_done    = (rx_cnt_q == CNT_LAST);

    case (rx_state_q)
      RX_IDLE: begin
        if (!sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        rx_cnt_d = bit_done ? '0 : rx_cnt_q + 1'b1;
        if (bit_done) begin
          rx_shift_d = {sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == DATA_LAST) begin
            perr_pend_d = 1'b0;
            rx_state_d  = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        rx_cnt_d = bit_done ? '0 : rx_cnt_q + 1'b1;
        if (bit_done) begin
          perr_pend_d = sync_q ^ calc_parity(rx_word, DATA_BITS, PARITY);
          rx_state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = bit_done ? '0 : rx_cnt_q + 1'b1;
        if (bit_done) begin
          deliver    = 1'b1;
          frame_bad  = ~sync_q;
          rx_state_d = sync_q ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A new byte may replace the held one only if it is free or being read this cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_word;
        rx_perr_d  = perr_pend_q;
        rx_ferr_d  = frame_bad;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      perr_pend_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
    end else begin
      meta_q      <= uart_rx;
      sync_q      <= meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      perr_pend_q <= perr_pend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_ovr_q    <= rx_ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: 8N1, 8E2 loopback and 8O1 instances at CLK_DIV=16,
// with a table of injected receive frames plus hand-written corner sequences.
module tb_uart_core;

  localparam int BIT = 16;

  logic clk;
  logic rst_n;
  logic inj_line;
  logic rdy;

  logic [7:0] n1_tx_data, e2_tx_data, o1_tx_data;
  logic       n1_tx_valid, e2_tx_valid, o1_tx_valid;
  logic       e2_rx_ready;
  logic       n1_uart_tx, e2_uart_tx, o1_uart_tx;
  logic       n1_tx_ready, e2_tx_ready, o1_tx_ready;
  logic [7:0] n1_rx_data, e2_rx_data, o1_rx_data;
  logic       n1_rx_valid, e2_rx_valid, o1_rx_valid;
  logic       n1_perr, e2_perr, o1_perr;
  logic       n1_ferr, e2_ferr, o1_ferr;
  logic       n1_ovr, e2_ovr, o1_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;

  typedef struct {
    logic [7:0] data;
    logic       flip_par;
    logic       stop_val;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_rec_t;

  rx_vec_t vecs [6];
  rx_rec_t lb_q [$];
  rx_rec_t lb_rec;

  uart_core #(.CLK_DIV(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(inj_line), .uart_tx(n1_uart_tx),
    .tx_data(n1_tx_data), .tx_valid(n1_tx_valid), .tx_ready(n1_tx_ready),
    .rx_data(n1_rx_data), .rx_valid(n1_rx_valid), .rx_ready(rdy),
    .rx_parity_err(n1_perr), .rx_frame_err(n1_ferr), .rx_overrun(n1_ovr)
  );

  uart_core #(.CLK_DIV(BIT), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_e2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(e2_uart_tx), .uart_tx(e2_uart_tx),
    .tx_data(e2_tx_data), .tx_valid(e2_tx_valid), .tx_ready(e2_tx_ready),
    .rx_data(e2_rx_data), .rx_valid(e2_rx_valid), .rx_ready(e2_rx_ready),
    .rx_parity_err(e2_perr), .rx_frame_err(e2_ferr), .rx_overrun(e2_ovr)
  );

  uart_core #(.CLK_DIV(BIT), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(inj_line), .uart_tx(o1_uart_tx),
    .tx_data(o1_tx_data), .tx_valid(o1_tx_valid), .tx_ready(o1_tx_ready),
    .rx_data(o1_rx_data), .rx_valid(o1_rx_valid), .rx_ready(rdy),
    .rx_parity_err(o1_perr), .rx_frame_err(o1_ferr), .rx_overrun(o1_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every byte handed over by the loopback receiver.
  always @(negedge clk) begin
    if (rst_n && e2_rx_valid && e2_rx_ready) begin
      lb_rec.d  = e2_rx_data;
      lb_rec.pe = e2_perr;
      lb_rec.fe = e2_ferr;
      lb_q.push_back(lb_rec);
    end
  end

  always @(negedge clk) begin
    if (n1_ovr) ovr_cnt++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one serial frame on inj_line; the line is left at the stop level.
  task automatic apply_stimulus(input logic [7:0] data, input logic has_par,
                                input logic par_bit, input logic stop_val);
    inj_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      inj_line = data[i];
      repeat (BIT) @(negedge clk);
    end
    if (has_par) begin
      inj_line = par_bit;
      repeat (BIT) @(negedge clk);
    end
    inj_line = stop_val;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    inj_line = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_tx;
    int         bit_err [10];
    int         ready_low;
    int         idle_err;
    int         low_cnt;
    int         vcnt;
    int         ovr_before;
    bit         done;

    vecs[0] = '{data: 8'h41, flip_par: 1'b0, stop_val: 1'b1, exp_data: 8'h41, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h41, flip_par: 1'b1, stop_val: 1'b1, exp_data: 8'h41, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h00, flip_par: 1'b0, stop_val: 1'b1, exp_data: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, flip_par: 1'b1, stop_val: 1'b1, exp_data: 8'hFF, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'hA5, flip_par: 1'b0, stop_val: 1'b0, exp_data: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[5] = '{data: 8'h3C, flip_par: 1'b0, stop_val: 1'b1, exp_data: 8'h3C, exp_perr: 1'b0, exp_ferr: 1'b0};

    rst_n       = 1'b0;
    inj_line    = 1'b1;
    rdy         = 1'b0;
    n1_tx_data  = 8'h00;
    n1_tx_valid = 1'b0;
    e2_tx_data  = 8'h00;
    e2_tx_valid = 1'b0;
    e2_rx_ready = 1'b1;
    o1_tx_data  = 8'h00;
    o1_tx_valid = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_uart_tx", n1_uart_tx, 1);
    check_output("rst_tx_ready", n1_tx_ready, 1);
    check_output("rst_rx_valid", n1_rx_valid, 0);
    check_output("rst_rx_data", n1_rx_data, 0);
    check_output("rst_perr", n1_perr, 0);
    check_output("rst_ferr", n1_ferr, 0);
    check_output("rst_overrun", n1_ovr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] 8N1 transmit of 0x41");
    exp_tx    = 10'b1010000010;
    ready_low = 0;
    idle_err  = 0;
    for (int i = 0; i < 10; i++) bit_err[i] = 0;
    n1_tx_data  = 8'h41;
    n1_tx_valid = 1'b1;
    for (int k = 0; k < 170; k++) begin
      @(negedge clk);
      if (k == 0) n1_tx_valid = 1'b0;
      if (!n1_tx_ready) ready_low++;
      if (k < 160) begin
        if (n1_uart_tx !== exp_tx[k / BIT]) bit_err[k / BIT]++;
      end else if (n1_uart_tx !== 1'b1) begin
        idle_err++;
      end
    end
    for (int i = 0; i < 10; i++) check_output($sformatf("tx_bit%0d_errs", i), bit_err[i], 0);
    check_output("tx_ready_low_cycles", ready_low, 160);
    check_output("tx_idle_after_errs", idle_err, 0);
    check_output("tx_ready_after", n1_tx_ready, 1);

    $display("[TB] 8E2 loopback of 0x42, 0x43");
    e2_tx_data  = 8'h42;
    e2_tx_valid = 1'b1;
    @(negedge clk);
    check_output("lb_ready_fall", e2_tx_ready, 0);
    e2_tx_data = 8'h43;
    low_cnt    = 1;
    done       = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (e2_tx_ready) done = 1'b1;
      else low_cnt++;
    end
    check_output("lb_frame_cycles", low_cnt, 192);
    @(negedge clk);
    e2_tx_valid = 1'b0;
    check_output("lb_gap_ready", e2_tx_ready, 0);
    check_output("lb_second_start", e2_uart_tx, 0);
    repeat (300) @(negedge clk);
    check_output("lb_count", lb_q.size(), 2);
    if (lb_q.size() == 2) begin
      check_output("lb_data0", lb_q[0].d, 8'h42);
      check_output("lb_errs0", {lb_q[0].pe, lb_q[0].fe}, 2'b00);
      check_output("lb_data1", lb_q[1].d, 8'h43);
      check_output("lb_errs1", {lb_q[1].pe, lb_q[1].fe}, 2'b00);
    end

    $display("[TB] 8O1 receive vector table");
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].data, 1'b1, (~^vecs[v].data) ^ vecs[v].flip_par, vecs[v].stop_val);
      inj_line = 1'b1;
      check_output($sformatf("o1_v%0d_valid", v), o1_rx_valid, 1);
      check_output($sformatf("o1_v%0d_data", v), o1_rx_data, vecs[v].exp_data);
      check_output($sformatf("o1_v%0d_perr", v), o1_perr, vecs[v].exp_perr);
      check_output($sformatf("o1_v%0d_ferr", v), o1_ferr, vecs[v].exp_ferr);
      consume();
      check_output($sformatf("o1_v%0d_cleared", v), o1_rx_valid, 0);
      idle_bits(1);
    end

    apply_reset();
    $display("[TB] framing error and break on 8N1");
    apply_stimulus(8'h43, 1'b0, 1'b0, 1'b0);
    check_output("brk_valid", n1_rx_valid, 1);
    check_output("brk_data", n1_rx_data, 8'h43);
    check_output("brk_ferr", n1_ferr, 1);
    consume();
    vcnt = 0;
    for (int k = 0; k < 11 * BIT; k++) begin
      @(negedge clk);
      if (n1_rx_valid) vcnt++;
    end
    check_output("brk_no_rx_while_low", vcnt, 0);
    idle_bits(2);
    apply_stimulus(8'h55, 1'b0, 1'b0, 1'b1);
    check_output("brk_next_valid", n1_rx_valid, 1);
    check_output("brk_next_data", n1_rx_data, 8'h55);
    check_output("brk_next_ferr", n1_ferr, 0);
    consume();
    idle_bits(1);

    $display("[TB] start glitch rejection");
    inj_line = 1'b0;
    repeat (5) @(negedge clk);
    inj_line = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 12 * BIT; k++) begin
      @(negedge clk);
      if (n1_rx_valid) vcnt++;
    end
    check_output("glitch_no_valid", vcnt, 0);
    apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b1);
    check_output("glitch_next_valid", n1_rx_valid, 1);
    check_output("glitch_next_data", n1_rx_data, 8'hA5);
    consume();
    idle_bits(1);

    $display("[TB] overrun with rx_ready held low");
    ovr_before = ovr_cnt;
    apply_stimulus(8'h41, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    apply_stimulus(8'h42, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_output("ovr_valid", n1_rx_valid, 1);
    check_output("ovr_data_kept", n1_rx_data, 8'h41);
    check_output("ovr_pulses", ovr_cnt - ovr_before, 1);
    consume();
    check_output("ovr_cleared", n1_rx_valid, 0);

    $display("[TB] reset in the middle of a transmit frame");
    @(negedge clk);
    n1_tx_data  = 8'h41;
    n1_tx_valid = 1'b1;
    @(negedge clk);
    n1_tx_valid = 1'b0;
    repeat (39) @(negedge clk);
    check_output("midtx_line_low", n1_uart_tx, 0);
    check_output("midtx_busy", n1_tx_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midtx_rst_uart_tx", n1_uart_tx, 1);
    check_output("midtx_rst_tx_ready", n1_tx_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART core for the 27 MHz fabric: an independent transmitter and receiver with configurable divisor, data width, parity and stop bits. It replaces ad-hoc per-project UART state machines. Both byte-side ports use a valid/ready handshake, so message ROMs, command decoders and LED pattern logic attach without sharing timing assumptions. The receiver adds input synchronisation, start-glitch rejection, parity and framing checks, and an overrun flag.

## Interface
- CLK_DIV, 234: clock cycles per bit (27 MHz / 115200); legal range ≥ 8.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2 stop bits (TX); RX always checks the first stop bit only.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  serial input, asynchronous, idle high
- uart_tx  out  1  serial output, idle high
- tx_data  in  8  byte to send; bits above DATA_BITS-1 ignored
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter can accept a byte
- rx_data  out  8  received byte, zero-extended above DATA_BITS
- rx_valid  out  1  rx_data holds an unread byte
- rx_ready  in  1  consumer takes rx_data
- rx_parity_err  out  1  parity error for the byte in rx_data; held with rx_data
- rx_frame_err  out  1  stop bit sampled low for the byte in rx_data; held with rx_data
- rx_overrun  out  1  one-cycle pulse when a completed byte is dropped

## Operation
- Reset values: uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0. Both FSMs return to IDLE. Reset mid-frame aborts the frame immediately; uart_tx goes high asynchronously.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1. On tx_valid&&tx_ready, latch tx_data and go to START.
  - START drives 0. DATA drives bits LSB first. PARITY is skipped when PARITY=0. STOP drives 1 for STOP_BITS bit times.
  - Each state lasts CLK_DIV cycles; a bit counter tracks DATA and STOP positions.
  - Parity bit: even = XOR of data bits; odd = its inverse.
- RX path: a 2-flop synchroniser feeds the FSM. All samples below are taken on the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a sampled 0 enters START and clears the counter.
  - START: at count CLK_DIV/2, re-sample. A 1 is a glitch; return to IDLE with no output. A 0 proceeds to DATA.
  - DATA: sample every CLK_DIV cycles (mid-bit), shifting LSB first.
  - PARITY: sample and compare against the computed parity. Skipped when PARITY=0.
  - STOP: sample mid-bit. A 1 returns to IDLE. A 0 sets the frame error and goes to BREAK, which waits for a sampled 1 before IDLE.
- Delivery happens on the stop-bit sample cycle:
  - If rx_valid=0, or rx_valid&&rx_ready in that same cycle: load rx_data and both error flags, and set rx_valid=1.
  - Otherwise, keep the old byte and flags, drop the new byte, and pulse rx_overrun for one cycle.
- rx_valid clears on rx_valid&&rx_ready when no new byte lands in the same cycle.

## Timing
- TX: handshake at cycle N; uart_tx falls at N+1.
- TX frame occupies exactly CLK_DIV×(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- tx_ready falls at N+1 and returns at the cycle after the last stop-bit cycle. Back-to-back frames therefore have no idle gap beyond 1 cycle.
- RX latency: rx_valid rises 1 cycle after the mid-stop-bit sample. Total delay from the real start edge is 2 (sync) + CLK_DIV/2 + CLK_DIV×(DATA_BITS+(PARITY!=0)+1) + 1 cycles.
- Bit-period counter width: $clog2(CLK_DIV). It wraps to 0 exactly at CLK_DIV-1, with no off-by-one drift across a frame.
- TX and RX are fully independent; loopback of uart_tx to uart_rx must work.

## Structure
- Package uart_pkg holds:
  - the PARITY encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the TX and RX state enums;
  - a function computing parity over DATA_BITS.
- Sub-module uart_tx_serializer contains the TX FSM, its counter and its shift register.
- The RX FSM, synchroniser and output holding register stay in uart_core.
- Simulation uses CLK_DIV=16.

## Test plan
- 8N1, CLK_DIV=16: send 0x41 → uart_tx shows 0,1,0,0,0,0,0,1,0,1, each held 16 cycles. tx_ready is low for 160 cycles.
- Loopback 8E2: send 0x42 then 0x43 back-to-back → rx_data=0x42, then 0x43, with both error flags 0. No idle gap beyond 1 cycle between frames.
- Inject an 8O1 frame of 0x41 with the parity bit flipped → rx_data=0x41 and rx_parity_err=1.
- Inject 0x43 with stop bit 0 and the line held low 3 bit times → rx_frame_err=1. The FSM stays in BREAK until the line goes high, then the next frame is received normally.
- Pulse uart_rx low for 5 cycles (< CLK_DIV/2) → no rx_valid, and a following valid frame is received correctly.
- Hold rx_ready=0 while injecting 0x41 then 0x42 → rx_data stays 0x41 and rx_overrun pulses once. Asserting rst_n=0 mid-TX frame → uart_tx=1 and tx_ready=1 immediately.
